hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 48 ++++
 rtl/hazard_ctrl_sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions: opcode constants, hazard FSM encoding, stage-control bundle.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Major opcodes, shared with the control decoder
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] SAVE   = 7'b0100011;
  localparam logic [6:0] BTYPE  = 7'b1100011;
  localparam logic [6:0] JTYPE  = 7'b1101111;
  localparam logic [6:0] JRTYPE = 7'b1100111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HUNG     = 2'd2
  } hz_state_t;

  // Per-cycle pipeline steering produced by the hazard unit
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic pipe_write;
    logic hazard_mux;
    logic ifid_flush;
  } hz_ctrl_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    logic u;
    case (op)
      RTYPE, ITYPE, LOAD, SAVE, BTYPE, JRTYPE: u = 1'b1;
      default:                                 u = 1'b0;
    endcase
    uses_rs1 = u;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    logic u;
    case (op)
      RTYPE, SAVE, BTYPE: u = 1'b1;
      default:            u = 1'b0;
    endcase
    uses_rs2 = u;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard unit's performance statistics.
// Latency: count visible one cycle after inc; holds at all-ones once reached.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, rst_n (async, active-low), inc (count enable), cnt (current value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use bubble, redirect squash, memory freeze, hang watchdog.
// Latency: control outputs are combinational (zero cycles); state/counters update on clk.
// Backpressure: icache/dcache stalls freeze every stage; a hang freezes until reset.
// Ports: id_* (ID-stage operands), ex_* (EX load/redirect info), *_stall (memory not ready)
//        -> hazard_mux, pc_write, ifid_write, pipe_write, ifid_flush, hung, perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             hazard_mux,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_write,
  output logic             ifid_flush,
  output logic             hung,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The wait counter only has to reach TIMEOUT-1; the hang is declared on that cycle
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  hz_state_t   state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  hz_ctrl_t    ctrl;
  logic        mem_stall;
  logic        load_use;
  logic        at_limit;
  logic        take_bubble;
  logic        take_flush;

  assign mem_stall = icache_stall | dcache_stall;
  assign at_limit  = (wait_cnt == WAIT_LAST);

  // x0 never carries a real dependency, and only operands the opcode actually reads count
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    (((ex_rd == id_rs1) && uses_rs1(id_opcode)) ||
                     ((ex_rd == id_rs2) && uses_rs2(id_opcode)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (mem_stall) state_nxt = at_limit ? ST_HUNG : ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (!mem_stall)    state_nxt = ST_RUN;
        else if (at_limit) state_nxt = ST_HUNG;
      end
      ST_HUNG: state_nxt = ST_HUNG;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Consecutive stall cycles; any ready cycle restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!mem_stall) begin
      wait_cnt <= '0;
    end else if (!at_limit) begin
      wait_cnt <= wait_cnt + WAIT_ONE;
    end
  end

  // Output decode in priority order. A redirect seen during a freeze needs no storage:
  // the frozen EX stage keeps presenting it until the first ready cycle.
  always_comb begin
    ctrl        = '{pc_write: 1'b1, ifid_write: 1'b1, pipe_write: 1'b1,
                    hazard_mux: 1'b0, ifid_flush: 1'b0};
    take_bubble = 1'b0;
    take_flush  = 1'b0;
    if (!rst_n) begin
      // keep the normal decode while held in reset
    end else if (state == ST_HUNG) begin
      ctrl = '0;
    end else if (mem_stall) begin
      ctrl = '0;
    end else if (ex_redirect) begin
      // squash both wrong-path instructions: IF/ID cleared, ID bubbled into EX
      ctrl       = '{pc_write: 1'b1, ifid_write: 1'b1, pipe_write: 1'b1,
                     hazard_mux: 1'b1, ifid_flush: 1'b1};
      take_flush = 1'b1;
    end else if (load_use) begin
      ctrl        = '{pc_write: 1'b0, ifid_write: 1'b0, pipe_write: 1'b1,
                      hazard_mux: 1'b1, ifid_flush: 1'b0};
      take_bubble = 1'b1;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign ifid_write = ctrl.ifid_write;
  assign pipe_write = ctrl.pipe_write;
  assign hazard_mux = ctrl.hazard_mux;
  assign ifid_flush = ctrl.ifid_flush;
  assign hung       = (state == ST_HUNG);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_stall | hung),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (take_bubble),
    .cnt   (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (take_flush),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vectors, reference model checked every cycle.
// Latency: model predicts zero-cycle control outputs and per-edge counter updates.
// Backpressure: n/a.
module tb_hazard_ctrl;

  localparam int TMO  = 255;
  localparam int CW   = 16;
  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  id_opcode = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        ex_memread = 1'b0, ex_redirect = 1'b0;
  logic        icache_stall = 1'b0, dcache_stall = 1'b0;
  logic        hazard_mux, pc_write, ifid_write, pipe_write, ifid_flush, hung;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .ex_redirect  (ex_redirect),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall),
    .hazard_mux   (hazard_mux),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .pipe_write   (pipe_write),
    .ifid_flush   (ifid_flush),
    .hung         (hung),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_run;          // consecutive stalled cycles seen
  bit m_hung;
  int m_stall, m_bubble, m_flush;

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // action: 0 normal, 1 hung, 2 freeze, 3 redirect, 4 bubble
  always @(negedge clk) begin : compare
    bit ms, lu;
    int act;
    bit e_pc, e_ifid, e_pipe, e_mux, e_flush;
    if (!rst_n) begin
      m_run = 0; m_hung = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
    end
    ms = icache_stall | dcache_stall;
    lu = ex_memread && (ex_rd != 0) &&
         ((ex_rd == id_rs1 && reads_rs1(id_opcode)) || (ex_rd == id_rs2 && reads_rs2(id_opcode)));
    if (!rst_n)           act = 0;
    else if (m_hung)      act = 1;
    else if (ms)          act = 2;
    else if (ex_redirect) act = 3;
    else if (lu)          act = 4;
    else                  act = 0;
    e_pc    = (act == 0) || (act == 3);
    e_ifid  = (act == 0) || (act == 3);
    e_pipe  = (act == 0) || (act == 3) || (act == 4);
    e_mux   = (act == 3) || (act == 4);
    e_flush = (act == 3);
    chk("pc_write",   32'(pc_write),   32'(e_pc));
    chk("ifid_write", 32'(ifid_write), 32'(e_ifid));
    chk("pipe_write", 32'(pipe_write), 32'(e_pipe));
    chk("hazard_mux", 32'(hazard_mux), 32'(e_mux));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
    chk("hung",       32'(hung),       32'(m_hung));
    chk("stall_cnt",  32'(stall_cnt),  m_stall);
    chk("bubble_cnt", 32'(bubble_cnt), m_bubble);
    chk("flush_cnt",  32'(flush_cnt),  m_flush);
    if (rst_n) begin
      if (ms || m_hung) m_stall = sat_inc(m_stall);
      if (act == 4) m_bubble = sat_inc(m_bubble);
      if (act == 3) m_flush = sat_inc(m_flush);
      if (ms) begin
        m_run++;
        if (m_run >= TMO) m_hung = 1;
      end else begin
        m_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_opcode = 7'b0010011; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    ex_memread = 0; ex_redirect = 0; icache_stall = 0; dcache_stall = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin : main
    int hung_at;
    idle();
    rst_n = 0;
    tick();
    tick();
    // reset state
    chk("rst_pc_write", 32'(pc_write), 1);
    chk("rst_mux", 32'(hazard_mux), 0);
    chk("rst_hung", 32'(hung), 0);
    chk("rst_bubble", 32'(bubble_cnt), 0);
    rst_n = 1;
    tick();

    // load-use on rs2 of an R-type
    ex_memread = 1; ex_rd = 5; id_opcode = 7'b0110011; id_rs1 = 1; id_rs2 = 5;
    #1;
    chk("lu_mux", 32'(hazard_mux), 1);
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_ifid_write", 32'(ifid_write), 0);
    chk("lu_pipe_write", 32'(pipe_write), 1);
    tick();
    idle();
    tick();
    chk("lu_bubble_cnt", 32'(bubble_cnt), 1);

    // x0 destination never stalls
    ex_memread = 1; ex_rd = 0; id_opcode = 7'b0010011; id_rs1 = 0;
    #1;
    chk("x0_pc_write", 32'(pc_write), 1);
    tick();
    // jal does not read rs1
    ex_memread = 1; ex_rd = 7; id_opcode = 7'b1101111; id_rs1 = 7;
    #1;
    chk("jal_pc_write", 32'(pc_write), 1);
    chk("jal_mux", 32'(hazard_mux), 0);
    tick();
    // store reads rs2
    ex_memread = 1; ex_rd = 9; id_opcode = 7'b0100011; id_rs1 = 1; id_rs2 = 9;
    #1;
    chk("sw_pc_write", 32'(pc_write), 0);
    tick();
    idle();
    tick();

    // redirect together with load-use
    do_reset();
    ex_redirect = 1; ex_memread = 1; ex_rd = 3; id_opcode = 7'b0000011; id_rs1 = 3;
    #1;
    chk("rd_lu_flush", 32'(ifid_flush), 1);
    chk("rd_lu_mux", 32'(hazard_mux), 1);
    chk("rd_lu_pc_write", 32'(pc_write), 1);
    tick();
    idle();
    tick();
    chk("rd_lu_flush_cnt", 32'(flush_cnt), 1);
    chk("rd_lu_bubble_cnt", 32'(bubble_cnt), 0);

    // dcache freeze with a pending redirect
    do_reset();
    dcache_stall = 1; ex_redirect = 1;
    #1;
    chk("frz_pc_write", 32'(pc_write), 0);
    chk("frz_flush", 32'(ifid_flush), 0);
    repeat (10) tick();
    dcache_stall = 0;
    #1;
    chk("frz_redirect_flush", 32'(ifid_flush), 1);
    tick();
    ex_redirect = 0;
    tick();
    chk("frz_stall_cnt", 32'(stall_cnt), 10);
    chk("frz_flush_cnt", 32'(flush_cnt), 1);

    // icache hang watchdog
    do_reset();
    icache_stall = 1;
    hung_at = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (hung_at == 0 && hung === 1'b1) hung_at = i;
    end
    chk("hang_cycles", hung_at, TMO);
    chk("hang_stall_cnt", 32'(stall_cnt), 300);
    icache_stall = 0;
    tick();
    tick();
    chk("hang_sticky", 32'(hung), 1);
    chk("hang_pc_write", 32'(pc_write), 0);
    #1;
    rst_n = 0;
    #1;
    chk("hang_async_clear", 32'(hung), 0);
    chk("hang_rst_pc_write", 32'(pc_write), 1);
    tick();
    rst_n = 1;
    tick();

    // bubble counter saturation
    do_reset();
    ex_memread = 1; ex_rd = 4; id_opcode = 7'b1100011; id_rs1 = 2; id_rs2 = 4;
    repeat (70000) tick();
    chk("sat_bubble_cnt", 32'(bubble_cnt), CMAX);
    idle();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
